// File: rtl/slm_spi_config_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : slm_spi_config_master
// Description : Mode-0 SPI master for 16-bit SLM configuration frames.
// Revision    : 1.0 - initial release
// ============================================================================
module slm_spi_config_master #(
  parameter int CLKS_PER_HALF_BIT = 4,
  parameter int CS_SETUP_CLKS     = 2,
  parameter int CS_HOLD_CLKS      = 2
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_enable_spi,
  input  logic       i_start_spi_transfer_cmd,
  input  logic [7:0] i_Tx_Upper_Byte,
  input  logic [7:0] i_Tx_Lower_Byte,
  output logic [7:0] o_Rx_Upper_Byte,
  output logic [7:0] o_Rx_Lower_Byte,
  output logic       o_transaction_complete,
  output logic       o_busy,
  output logic       o_spi_cs_n,
  output logic       o_spi_sclk,
  output logic       o_spi_mosi,
  input  logic       i_spi_miso
);

  // One shared counter times CS setup, SCLK half-periods and CS hold.
  localparam int c_MAX_A  = (CLKS_PER_HALF_BIT > CS_SETUP_CLKS) ? CLKS_PER_HALF_BIT : CS_SETUP_CLKS;
  localparam int c_MAX_B  = (c_MAX_A > CS_HOLD_CLKS) ? c_MAX_A : CS_HOLD_CLKS;
  localparam int c_CNT_W  = (c_MAX_B > 1) ? $clog2(c_MAX_B) : 1;

  localparam logic [c_CNT_W-1:0] c_HALF_LAST  = c_CNT_W'(CLKS_PER_HALF_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(CS_SETUP_CLKS - 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(CS_HOLD_CLKS - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
  localparam logic [3:0]         c_LAST_BIT   = 4'd15;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_SETUP = 3'd1;
  localparam logic [2:0] c_ST_SHIFT = 3'd2;
  localparam logic [2:0] c_ST_HOLD  = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [3:0]         r_bit_cnt;
  logic               r_sclk;
  logic [15:0]        r_tx_shift;
  logic [15:0]        r_rx_shift;
  logic [7:0]         r_rx_upper;
  logic [7:0]         r_rx_lower;

  logic w_setup_done;
  logic w_half_done;
  logic w_hold_done;
  logic w_last_bit;
  logic w_frame_active;

  assign w_setup_done   = (r_cnt == c_SETUP_LAST);
  assign w_half_done    = (r_cnt == c_HALF_LAST);
  assign w_hold_done    = (r_cnt == c_HOLD_LAST);
  assign w_last_bit     = (r_bit_cnt == c_LAST_BIT);
  assign w_frame_active = (r_state == c_ST_SETUP) || (r_state == c_ST_SHIFT) ||
                          (r_state == c_ST_HOLD);

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a low enable abandons any frame in flight
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      c_ST_IDLE: begin
        if (i_start_spi_transfer_cmd && i_enable_spi) begin
          w_next_state = c_ST_SETUP;
        end
      end
      c_ST_SETUP: begin
        if (!i_enable_spi) begin
          w_next_state = c_ST_IDLE;
        end else if (w_setup_done) begin
          w_next_state = c_ST_SHIFT;
        end
      end
      c_ST_SHIFT: begin
        if (!i_enable_spi) begin
          w_next_state = c_ST_IDLE;
        end else if (r_sclk && w_half_done && w_last_bit) begin
          w_next_state = c_ST_HOLD;
        end
      end
      c_ST_HOLD: begin
        if (!i_enable_spi) begin
          w_next_state = c_ST_IDLE;
        end else if (w_hold_done) begin
          w_next_state = c_ST_DONE;
        end
      end
      c_ST_DONE: begin
        w_next_state = c_ST_IDLE;
      end
      default: begin
        w_next_state = c_ST_IDLE;
      end
    endcase
  end

  // Datapath: timing counter, SCLK phase and the two shift registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_sclk     <= 1'b0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_upper <= '0;
      r_rx_lower <= '0;
    end else if (w_next_state == c_ST_IDLE) begin
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_sclk    <= 1'b0;
    end else begin
      unique case (r_state)
        c_ST_IDLE: begin
          r_cnt      <= '0;
          r_tx_shift <= {i_Tx_Upper_Byte, i_Tx_Lower_Byte};
          r_rx_shift <= '0;
        end
        c_ST_SETUP: begin
          r_cnt <= w_setup_done ? '0 : (r_cnt + c_CNT_ONE);
        end
        c_ST_SHIFT: begin
          if (w_half_done) begin
            r_cnt <= '0;
            if (!r_sclk) begin
              r_sclk     <= 1'b1;
              r_rx_shift <= {r_rx_shift[14:0], i_spi_miso};
            end else begin
              r_sclk     <= 1'b0;
              r_tx_shift <= {r_tx_shift[14:0], 1'b0};
              r_bit_cnt  <= r_bit_cnt + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        c_ST_HOLD: begin
          r_cnt <= w_hold_done ? '0 : (r_cnt + c_CNT_ONE);
          if (w_next_state == c_ST_DONE) begin
            r_rx_upper <= r_rx_shift[15:8];
            r_rx_lower <= r_rx_shift[7:0];
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Moore outputs; MOSI is forced low whenever no frame is on the wire
  always_comb begin
    o_busy                 = (r_state != c_ST_IDLE);
    o_spi_cs_n             = !w_frame_active;
    o_transaction_complete = (r_state == c_ST_DONE);
    o_spi_sclk             = r_sclk;
    o_spi_mosi             = w_frame_active & r_tx_shift[15];
  end

  assign o_Rx_Upper_Byte = r_rx_upper;
  assign o_Rx_Lower_Byte = r_rx_lower;

endmodule
`default_nettype wire
